// File: rtl/exec_sequencer_pkg.sv
// Shared widths, operand-location and sequencer-state types for the execution sequencer.
package exec_sequencer_pkg;
  localparam int OPCODE_WIDTH = 6;
  localparam int VALUE_WIDTH  = 8;
  localparam int MEM_WIDTH    = 8;

  typedef enum logic [1:0] {
    CH_REG  = 2'b00,
    CH_MEM  = 2'b01,
    CH_IMM  = 2'b10,
    CH_NONE = 2'b11
  } choice_t;

  typedef enum logic [2:0] {
    IDLE, S1_REQ, S1_DATA, S2_REQ, S2_DATA, EXEC, WB
  } state_t;

  // Immediate fields are zero-extended, or truncated to the low value bits.
  function automatic logic [VALUE_WIDTH-1:0] imm_to_value(input logic [MEM_WIDTH-1:0] f);
    return VALUE_WIDTH'(f);
  endfunction
endpackage

// File: rtl/exec_sequencer_operand_select.sv
// Operand mux: choice + field + rf read data -> operand value; combinational, no flow control.
// Memory operands resolve to 0 here and are filled in later by the sequencer.
module exec_sequencer_operand_select
  import exec_sequencer_pkg::*;
(
  input  choice_t                i_choice,
  input  logic [MEM_WIDTH-1:0]   i_field,
  input  logic [VALUE_WIDTH-1:0] i_rf_rdata,
  output logic [VALUE_WIDTH-1:0] o_value
);
  always_comb begin
    o_value = '0;
    case (i_choice)
      CH_REG:  o_value = i_rf_rdata;
      CH_IMM:  o_value = imm_to_value(i_field);
      default: o_value = '0;
    endcase
  end
endmodule

// File: rtl/exec_sequencer.sv
// One-instruction-at-a-time sequencer: accept, mem reads, EXEC, WB; 3 cycles + 2 per mem source.
// Accepts only in IDLE; stalls indefinitely on mem_gnt with the memory request held stable.
module exec_sequencer
  import exec_sequencer_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_instr_valid,
  output logic                    o_instr_ready,
  input  logic [OPCODE_WIDTH-1:0] i_op_code,
  input  logic [MEM_WIDTH-1:0]    i_source1_addr,
  input  logic [MEM_WIDTH-1:0]    i_source2_addr,
  input  logic [MEM_WIDTH-1:0]    i_dest_addr,
  input  logic [1:0]              i_source1_choice,
  input  logic [1:0]              i_source2_choice,
  input  logic [1:0]              i_dest_choice,
  output logic [MEM_WIDTH-1:0]    o_rf_raddr1,
  output logic [MEM_WIDTH-1:0]    o_rf_raddr2,
  input  logic [VALUE_WIDTH-1:0]  i_rf_rdata1,
  input  logic [VALUE_WIDTH-1:0]  i_rf_rdata2,
  output logic                    o_rf_we,
  output logic [MEM_WIDTH-1:0]    o_rf_waddr,
  output logic [VALUE_WIDTH-1:0]  o_rf_wdata,
  output logic                    o_mem_req,
  output logic                    o_mem_we,
  output logic [MEM_WIDTH-1:0]    o_mem_addr,
  output logic [VALUE_WIDTH-1:0]  o_mem_wdata,
  input  logic                    i_mem_gnt,
  input  logic [VALUE_WIDTH-1:0]  i_mem_rdata,
  output logic [OPCODE_WIDTH-1:0] o_alu_op,
  output logic [VALUE_WIDTH-1:0]  o_alu_a,
  output logic [VALUE_WIDTH-1:0]  o_alu_b,
  input  logic [VALUE_WIDTH-1:0]  i_alu_out,
  output logic                    o_busy,
  output logic                    o_done
);
  state_t                  r_state, w_state_nxt;
  logic [OPCODE_WIDTH-1:0] r_op;
  logic [MEM_WIDTH-1:0]    r_s1_addr, r_s2_addr, r_dst_addr;
  choice_t                 r_s2_ch, r_dst_ch;
  logic [VALUE_WIDTH-1:0]  r_alu_a, r_alu_b, r_result;
  logic                    r_done;

  choice_t                 w_s1_ch_in, w_s2_ch_in, w_dst_ch_in;
  logic [VALUE_WIDTH-1:0]  w_opnd1, w_opnd2;
  logic                    w_accept;

  assign w_s1_ch_in  = choice_t'(i_source1_choice);
  assign w_s2_ch_in  = choice_t'(i_source2_choice);
  assign w_dst_ch_in = choice_t'(i_dest_choice);
  assign w_accept    = i_instr_valid && (r_state == IDLE);

  exec_sequencer_operand_select u_operand_select1 (
    .i_choice   (w_s1_ch_in),
    .i_field    (i_source1_addr),
    .i_rf_rdata (i_rf_rdata1),
    .o_value    (w_opnd1)
  );

  exec_sequencer_operand_select u_operand_select2 (
    .i_choice   (w_s2_ch_in),
    .i_field    (i_source2_addr),
    .i_rf_rdata (i_rf_rdata2),
    .o_value    (w_opnd2)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    o_instr_ready = 1'b0;
    o_rf_raddr1   = r_s1_addr;
    o_rf_raddr2   = r_s2_addr;
    o_rf_we       = 1'b0;
    o_mem_req     = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    case (r_state)
      IDLE: begin
        o_instr_ready = 1'b1;
        o_rf_raddr1   = i_source1_addr;
        o_rf_raddr2   = i_source2_addr;
        if (i_instr_valid) begin
          if (w_s1_ch_in == CH_MEM)      w_state_nxt = S1_REQ;
          else if (w_s2_ch_in == CH_MEM) w_state_nxt = S2_REQ;
          else                           w_state_nxt = EXEC;
        end
      end
      S1_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_s1_addr;
        if (i_mem_gnt) w_state_nxt = S1_DATA;
      end
      S1_DATA: w_state_nxt = (r_s2_ch == CH_MEM) ? S2_REQ : EXEC;
      S2_REQ: begin
        o_mem_req  = 1'b1;
        o_mem_addr = r_s2_addr;
        if (i_mem_gnt) w_state_nxt = S2_DATA;
      end
      S2_DATA: w_state_nxt = EXEC;
      EXEC:    w_state_nxt = WB;
      WB: begin
        if (r_dst_ch == CH_REG) begin
          o_rf_we     = 1'b1;
          w_state_nxt = IDLE;
        end else if (r_dst_ch == CH_MEM) begin
          o_mem_req  = 1'b1;
          o_mem_we   = 1'b1;
          o_mem_addr = r_dst_addr;
          if (i_mem_gnt) w_state_nxt = IDLE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_op       <= '0;
      r_s1_addr  <= '0;
      r_s2_addr  <= '0;
      r_dst_addr <= '0;
      r_s2_ch    <= CH_NONE;
      r_dst_ch   <= CH_NONE;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_result   <= '0;
      r_done     <= 1'b0;
    end else begin
      // Pulses in the cycle the FSM is back in IDLE; reset never produces it.
      r_done <= (r_state != IDLE) && (w_state_nxt == IDLE);
      if (w_accept) begin
        r_op       <= i_op_code;
        r_s1_addr  <= i_source1_addr;
        r_s2_addr  <= i_source2_addr;
        r_dst_addr <= i_dest_addr;
        r_s2_ch    <= w_s2_ch_in;
        r_dst_ch   <= w_dst_ch_in;
        r_alu_a    <= w_opnd1;
        r_alu_b    <= w_opnd2;
      end
      if (r_state == S1_DATA) r_alu_a  <= i_mem_rdata;
      if (r_state == S2_DATA) r_alu_b  <= i_mem_rdata;
      if (r_state == EXEC)    r_result <= i_alu_out;
    end
  end

  assign o_rf_waddr  = r_dst_addr;
  assign o_rf_wdata  = r_result;
  assign o_mem_wdata = r_result;
  assign o_alu_op    = r_op;
  assign o_alu_a     = r_alu_a;
  assign o_alu_b     = r_alu_b;
  assign o_busy      = (r_state != IDLE);
  assign o_done      = r_done;
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with a behavioural ALU, data memory and write monitors.
module tb_exec_sequencer;
  import exec_sequencer_pkg::*;

  localparam logic [5:0] OP_ADD = 6'd1;
  localparam logic [5:0] OP_SUB = 6'd2;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid, instr_ready;
  logic [5:0] op_code;
  logic [7:0] source1_addr, source2_addr, dest_addr;
  logic [1:0] source1_choice, source2_choice, dest_choice;
  logic [7:0] rf_raddr1, rf_raddr2, rf_rdata1, rf_rdata2;
  logic       rf_we;
  logic [7:0] rf_waddr, rf_wdata;
  logic       mem_req, mem_we, mem_gnt;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;
  logic [5:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_out;
  logic       busy, done;

  int total = 0, bad = 0;
  int cyc = 0, acc_cyc = 0;
  int acc_cnt = 0, done_cnt = 0, rf_we_cnt = 0, wr_cnt = 0, rd_cnt = 0;
  logic [7:0] last_waddr = 0, last_wdata = 0, wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic [7:0] mem_arr [256];

  exec_sequencer dut (
    .i_clk(clk), .i_rst(rst), .i_instr_valid(instr_valid), .o_instr_ready(instr_ready),
    .i_op_code(op_code), .i_source1_addr(source1_addr), .i_source2_addr(source2_addr),
    .i_dest_addr(dest_addr), .i_source1_choice(source1_choice),
    .i_source2_choice(source2_choice), .i_dest_choice(dest_choice),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2), .i_rf_rdata1(rf_rdata1),
    .i_rf_rdata2(rf_rdata2), .o_rf_we(rf_we), .o_rf_waddr(rf_waddr), .o_rf_wdata(rf_wdata),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
    .i_mem_gnt(mem_gnt), .i_mem_rdata(mem_rdata), .o_alu_op(alu_op), .o_alu_a(alu_a),
    .o_alu_b(alu_b), .i_alu_out(alu_out), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign alu_out = (alu_op == OP_ADD) ? alu_a + alu_b :
                   (alu_op == OP_SUB) ? alu_a - alu_b : alu_a ^ alu_b;

  // Observe handshakes mid-cycle, when DUT outputs and bench inputs are settled.
  always @(negedge clk) begin
    if (instr_valid && instr_ready) acc_cnt++;
    if (done) done_cnt++;
    if (rf_we) begin
      rf_we_cnt++;
      last_waddr = rf_waddr;
      last_wdata = rf_wdata;
    end
    if (mem_req && mem_gnt) begin
      if (mem_we) begin
        wr_cnt++;
        wr_addr = mem_addr;
        wr_data = mem_wdata;
        mem_arr[mem_addr] = mem_wdata;
      end else begin
        rd_cnt++;
        rd_addr = mem_addr;
        mem_rdata = mem_arr[mem_addr];
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
                           input logic [7:0] d, input logic [1:0] c1, input logic [1:0] c2,
                           input logic [1:0] cd);
    op_code = op; source1_addr = a1; source2_addr = a2; dest_addr = d;
    source1_choice = c1; source2_choice = c2; dest_choice = cd;
  endtask

  task automatic issue(input logic [5:0] op, input logic [7:0] a1, input logic [7:0] a2,
                       input logic [7:0] d, input logic [1:0] c1, input logic [1:0] c2,
                       input logic [1:0] cd);
    set_instr(op, a1, a2, d, c1, c2, cd);
    instr_valid = 1'b1;
    acc_cyc = cyc;
    step();
    instr_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk(tag, done, 1);
  endtask

  int a0, w0, m0, r0, d0, d1;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
    mem_rdata = 8'h00;
    rst = 1'b1; instr_valid = 1'b0; mem_gnt = 1'b1;
    rf_rdata1 = 8'h00; rf_rdata2 = 8'h00;
    set_instr(6'd0, 8'h00, 8'h00, 8'h00, CH_REG, CH_REG, CH_REG);
    step(); step();

    chk("rst_ready", instr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    rst = 1'b0;
    step();

    // reg/reg -> reg ADD
    rf_rdata1 = 8'd3; rf_rdata2 = 8'd4;
    set_instr(OP_ADD, 8'h01, 8'h02, 8'h05, CH_REG, CH_REG, CH_REG);
    #1;
    chk("t1_raddr1", rf_raddr1, 8'h01);
    chk("t1_raddr2", rf_raddr2, 8'h02);
    w0 = rf_we_cnt;
    issue(OP_ADD, 8'h01, 8'h02, 8'h05, CH_REG, CH_REG, CH_REG);
    chk("t1_busy", busy, 1);
    chk("t1_ready", instr_ready, 0);
    wait_done("t1_done");
    chk("t1_lat", cyc - acc_cyc, 3);
    chk("t1_rf_we_cnt", rf_we_cnt - w0, 1);
    chk("t1_waddr", last_waddr, 8'h05);
    chk("t1_wdata", last_wdata, 8'h07);
    chk("t1_alu_op", alu_op, OP_ADD);
    step();
    chk("t1_done_pulse", done, 0);

    // mem/imm -> mem SUB
    mem_arr[8'h10] = 8'h22;
    r0 = rd_cnt; m0 = wr_cnt; w0 = rf_we_cnt;
    issue(OP_SUB, 8'h10, 8'h05, 8'h11, CH_MEM, CH_IMM, CH_MEM);
    chk("t2_rd_req", mem_req, 1);
    chk("t2_rd_addr_out", mem_addr, 8'h10);
    chk("t2_rd_we", mem_we, 0);
    wait_done("t2_done");
    chk("t2_lat", cyc - acc_cyc, 5);
    chk("t2_rd_cnt", rd_cnt - r0, 1);
    chk("t2_rd_addr", rd_addr, 8'h10);
    chk("t2_wr_cnt", wr_cnt - m0, 1);
    chk("t2_wr_addr", wr_addr, 8'h11);
    chk("t2_wr_data", wr_data, 8'h1D);
    chk("t2_no_rf_we", rf_we_cnt - w0, 0);
    step();

    // reg/mem -> reg with 4-cycle grant stall on the source2 read
    mem_arr[8'h20] = 8'h09;
    rf_rdata1 = 8'd3;
    mem_gnt = 1'b0;
    r0 = rd_cnt;
    issue(OP_ADD, 8'h01, 8'h20, 8'h06, CH_REG, CH_MEM, CH_REG);
    for (int i = 0; i < 4; i++) begin
      chk("t3_stall_req", mem_req, 1);
      chk("t3_stall_addr", mem_addr, 8'h20);
      step();
    end
    mem_gnt = 1'b1;
    wait_done("t3_done");
    chk("t3_lat", cyc - acc_cyc, 9);
    chk("t3_rd_cnt", rd_cnt - r0, 1);
    chk("t3_waddr", last_waddr, 8'h06);
    chk("t3_wdata", last_wdata, 8'h0C);
    step();

    // dest none, instr_valid held high and fields wiggled while busy
    rf_rdata1 = 8'd3; rf_rdata2 = 8'd4;
    set_instr(OP_ADD, 8'h01, 8'h02, 8'h00, CH_REG, CH_REG, CH_NONE);
    a0 = acc_cnt; w0 = rf_we_cnt; m0 = wr_cnt;
    instr_valid = 1'b1;
    acc_cyc = cyc;
    step();
    rf_rdata1 = 8'h50; source1_addr = 8'h44;
    wait_done("t4_done");
    instr_valid = 1'b0;
    chk("t4_lat", cyc - acc_cyc, 3);
    step();
    chk("t4_acc_cnt", acc_cnt - a0, 1);
    chk("t4_no_rf_we", rf_we_cnt - w0, 0);
    chk("t4_no_mem_wr", wr_cnt - m0, 0);
    chk("t4_alu_a", alu_a, 8'd3);

    // reset while a mem writeback is stalled
    mem_gnt = 1'b0;
    issue(OP_ADD, 8'h07, 8'h01, 8'h30, CH_IMM, CH_IMM, CH_MEM);
    step();
    chk("t5_wr_req", mem_req, 1);
    chk("t5_wr_we", mem_we, 1);
    chk("t5_wr_wdata", mem_wdata, 8'h08);
    step(); step();
    chk("t5_wr_addr_hold", mem_addr, 8'h30);
    d0 = done_cnt; m0 = wr_cnt;
    #3 rst = 1'b1;
    #2;
    chk("t5_rst_req", mem_req, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", instr_ready, 1);
    step();
    rst = 1'b0;
    chk("t5_no_done_a", done, 0);
    step();
    chk("t5_no_done_b", done, 0);
    chk("t5_done_cnt", done_cnt - d0, 0);
    chk("t5_wr_abandoned", wr_cnt - m0, 0);
    mem_gnt = 1'b1;
    rf_rdata1 = 8'h10; rf_rdata2 = 8'h20;
    issue(OP_ADD, 8'h03, 8'h04, 8'h07, CH_REG, CH_REG, CH_REG);
    wait_done("t5_next_done");
    chk("t5_next_lat", cyc - acc_cyc, 3);
    chk("t5_next_waddr", last_waddr, 8'h07);
    chk("t5_next_wdata", last_wdata, 8'h30);
    step();

    // back-to-back with instr_valid held high
    rf_rdata1 = 8'd1; rf_rdata2 = 8'd2;
    set_instr(OP_ADD, 8'h00, 8'h00, 8'h01, CH_REG, CH_REG, CH_REG);
    a0 = acc_cnt; w0 = rf_we_cnt;
    instr_valid = 1'b1;
    step();
    rf_rdata1 = 8'd5; rf_rdata2 = 8'd6; dest_addr = 8'h02;
    wait_done("t6_done1");
    chk("t6_ready_in_done", instr_ready, 1);
    chk("t6_first_waddr", last_waddr, 8'h01);
    chk("t6_first_wdata", last_wdata, 8'h03);
    d1 = cyc;
    step();
    chk("t6_second_busy", busy, 1);
    wait_done("t6_done2");
    instr_valid = 1'b0;
    chk("t6_done_gap", cyc - d1, 3);
    chk("t6_second_waddr", last_waddr, 8'h02);
    chk("t6_second_wdata", last_wdata, 8'h0B);
    step();
    chk("t6_acc_cnt", acc_cnt - a0, 2);
    chk("t6_rf_we_cnt", rf_we_cnt - w0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
